// File: rtl/tone_sequencer.sv
// Tone sequencer: drives the shared clock divider's divisor and an audio gate,
// either from a switch-selected note (manual) or a 16-step programmable pattern.
module tone_sequencer #(
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 1_250_000
) (
  input  logic        inclk,
  input  logic        Reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic [3:0]  last_step,
  input  logic        manual_en,
  input  logic [2:0]  manual_note,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [31:0] div_clk_count,
  output logic        tone_en,
  output logic        busy,
  output logic [3:0]  step_idx,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_MANUAL, S_PLAY, S_GAP, S_DONE} state_t;

  localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

  function automatic logic [31:0] note_div(input logic [2:0] n);
    case (n)
      3'd0:    note_div = 32'd47801;
      3'd1:    note_div = 32'd42589;
      3'd2:    note_div = 32'd37936;
      3'd3:    note_div = 32'd35817;
      3'd4:    note_div = 32'd31928;
      3'd5:    note_div = 32'd28409;
      3'd6:    note_div = 32'd25329;
      default: note_div = 32'd23900;
    endcase
  endfunction

  state_t      r_state, w_next;
  logic [7:0]  r_ram [16];
  logic [31:0] r_div, r_cyc;
  logic [3:0]  r_step, r_beat, r_beats, r_last;
  logic        r_rest, r_loop;
  logic        w_load, w_step_done, w_play_end, w_gap_end;
  logic [3:0]  w_idx;

  // r_cyc counts cycles within a beat (PLAY) or within the gap (GAP)
  assign w_play_end = (r_cyc == BEAT_LAST) && (r_beat == r_beats);
  assign w_gap_end  = (r_cyc == GAP_LAST);

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_idx       = r_step;
    w_step_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_next = S_PLAY;
          w_load = 1'b1;
          w_idx  = 4'd0;
        end else if (manual_en && !stop) begin
          w_next = S_MANUAL;
        end
      end
      S_MANUAL: if (stop || !manual_en) w_next = S_IDLE;
      S_PLAY: begin
        if (stop)                 w_next = S_IDLE;
        else if (w_play_end) begin
          if (GAP_CYCLES != 0)    w_next = S_GAP;
          else                    w_step_done = 1'b1;
        end
      end
      S_GAP: begin
        if (stop)           w_next = S_IDLE;
        else if (w_gap_end) w_step_done = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_step_done) begin
      if (r_step < r_last) begin
        w_next = S_PLAY;
        w_load = 1'b1;
        w_idx  = r_step + 4'd1;
      end else if (r_loop) begin
        w_next = S_PLAY;
        w_load = 1'b1;
        w_idx  = 4'd0;
      end else begin
        w_next = S_DONE;
      end
    end
  end

  always_ff @(posedge inclk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      for (int i = 0; i < 16; i++) r_ram[i] <= 8'h00;
      r_div   <= 32'd0;
      r_cyc   <= 32'd0;
      r_step  <= 4'd0;
      r_beat  <= 4'd0;
      r_beats <= 4'd0;
      r_last  <= 4'd0;
      r_rest  <= 1'b0;
      r_loop  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (wr_en) r_ram[wr_addr] <= wr_data;
      // Step entry is captured here, so later writes only affect the next load
      if (w_load) begin
        r_step  <= w_idx;
        r_div   <= note_div(r_ram[w_idx][6:4]);
        r_rest  <= r_ram[w_idx][7];
        r_beats <= r_ram[w_idx][3:0];
      end else if (w_next == S_MANUAL) begin
        r_div <= note_div(manual_note);
      end
      if (w_load && r_state == S_IDLE) begin
        r_last <= last_step;
        r_loop <= loop;
      end
      if (w_load || w_next != r_state) begin
        r_cyc  <= 32'd0;
        r_beat <= 4'd0;
      end else if (r_state == S_PLAY && r_cyc == BEAT_LAST) begin
        r_cyc  <= 32'd0;
        r_beat <= r_beat + 4'd1;
      end else if (r_state == S_PLAY || r_state == S_GAP) begin
        r_cyc <= r_cyc + 32'd1;
      end
    end
  end

  assign div_clk_count = r_div;
  assign step_idx      = r_step;
  assign tone_en       = (r_state == S_PLAY && !r_rest) || (r_state == S_MANUAL);
  assign busy          = (r_state == S_PLAY) || (r_state == S_GAP) || (r_state == S_MANUAL);
  assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed scenarios plus random patterns, checked
// cycle by cycle against an expected-output timeline built from the step rules.
module tb_tone_sequencer;

  localparam int BEAT = 4;
  localparam int GAP  = 2;

  logic        inclk = 1'b0, Reset = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [3:0]  last_step = 4'd0, wr_addr = 4'd0;
  logic        manual_en = 1'b0, wr_en = 1'b0;
  logic [2:0]  manual_note = 3'd0;
  logic [7:0]  wr_data = 8'h00;
  logic [31:0] div_clk_count;
  logic        tone_en, busy, done;
  logic [3:0]  step_idx;

  tone_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .inclk(inclk), .Reset(Reset), .start(start), .stop(stop), .loop(loop),
    .last_step(last_step), .manual_en(manual_en), .manual_note(manual_note),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .div_clk_count(div_clk_count), .tone_en(tone_en), .busy(busy),
    .step_idx(step_idx), .done(done)
  );

  always #5 inclk = ~inclk;

  typedef struct {
    logic [31:0] div;
    logic        tone, busy;
    logic [3:0]  step;
    logic        done;
  } exp_t;

  int unsigned ntab [8] = '{47801, 42589, 37936, 35817, 31928, 28409, 25329, 23900};
  logic [7:0]  mram [16];
  exp_t        exp_q [$];
  logic [31:0] cur_div, p_div;
  logic [3:0]  cur_step, p_step;
  int          n_vec = 0, n_err = 0;

  task automatic tick();
    @(posedge inclk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".div"},  div_clk_count, e.div);
    chk({tag, ".tone"}, 32'(tone_en),  32'(e.tone));
    chk({tag, ".busy"}, 32'(busy),     32'(e.busy));
    chk({tag, ".step"}, 32'(step_idx), 32'(e.step));
    chk({tag, ".done"}, 32'(done),     32'(e.done));
  endtask

  task automatic chk_idle(input string tag);
    exp_t e;
    e = '{div: cur_div, tone: 1'b0, busy: 1'b0, step: cur_step, done: 1'b0};
    chk_all(tag, e);
  endtask

  function automatic int plen(input int idx);
    return (int'(mram[idx][3:0]) + 1) * BEAT;
  endfunction

  // One pattern step: play_n audible (or rest) cycles, then gap_n silent cycles
  task automatic push_step(input int idx, input int play_n, input int gap_n);
    p_div  = 32'(ntab[mram[idx][6:4]]);
    p_step = 4'(idx);
    for (int i = 0; i < play_n; i++)
      exp_q.push_back('{div: p_div, tone: ~mram[idx][7], busy: 1'b1, step: p_step, done: 1'b0});
    for (int i = 0; i < gap_n; i++)
      exp_q.push_back('{div: p_div, tone: 1'b0, busy: 1'b1, step: p_step, done: 1'b0});
  endtask

  task automatic push_done();
    exp_q.push_back('{div: p_div, tone: 1'b0, busy: 1'b0, step: p_step, done: 1'b1});
  endtask

  task automatic run_n(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk_all(tag, e);
      cur_div  = e.div;
      cur_step = e.step;
      tick();
    end
  endtask

  task automatic wr(input int addr, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_data = d;
    tick();
    wr_en = 1'b0;
    mram[addr] = d;
  endtask

  task automatic do_start(input logic [3:0] last, input logic lp);
    last_step = last; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mram[i] = 8'h00;
    cur_div = 32'd0; cur_step = 4'd0;
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    #1 Reset = 1'b1;
    #1 chk_idle("reset_async");
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk_idle("reset_idle");

    // Two-step pattern, no loop
    wr(0, 8'h01); wr(1, 8'h20);
    push_step(0, plen(0), GAP); push_step(1, plen(1), GAP); push_done();
    do_start(4'd1, 1'b0);
    run_n("t1", exp_q.size());
    chk_idle("t1_end");

    // Single rest step
    wr(0, 8'hD0);
    push_step(0, plen(0), GAP); push_done();
    do_start(4'd0, 1'b0);
    run_n("t2", exp_q.size());
    chk_idle("t2_end");

    // Looping pattern, stopped during the gap
    wr(0, 8'h01); wr(1, 8'h20);
    push_step(0, plen(0), GAP); push_step(1, plen(1), GAP);
    push_step(0, plen(0), GAP); push_step(1, plen(1), 1);
    do_start(4'd1, 1'b1);
    run_n("t3", exp_q.size());
    stop = 1'b1; tick(); stop = 1'b0;
    chk_idle("t3_stop");
    tick();
    chk_idle("t3_nodone");

    // Manual mode
    manual_en = 1'b1; manual_note = 3'd5;
    tick();
    cur_div = 32'(ntab[5]);
    chk_all("t4_m5", '{div: cur_div, tone: 1'b1, busy: 1'b1, step: cur_step, done: 1'b0});
    manual_note = 3'd7;
    tick();
    cur_div = 32'(ntab[7]);
    chk_all("t4_m7", '{div: cur_div, tone: 1'b1, busy: 1'b1, step: cur_step, done: 1'b0});
    start = 1'b1; tick(); start = 1'b0;
    chk_all("t4_start_ign", '{div: cur_div, tone: 1'b1, busy: 1'b1, step: cur_step, done: 1'b0});
    manual_en = 1'b0;
    tick();
    chk_idle("t4_off");

    // start beats manual_en; stop beats start
    push_step(0, 2, 0);
    start = 1'b1; manual_en = 1'b1;
    tick();
    start = 1'b0; manual_en = 1'b0;
    run_n("t5_play", 2);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_idle("t5_stop");
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk_idle("t5_both");
    tick();
    chk_idle("t5_stay");

    // Write to the playing entry, then reset mid-step
    wr(0, 8'h01);
    push_step(0, plen(0), GAP);
    mram[0] = 8'h70;
    push_step(0, 2, 0);
    do_start(4'd0, 1'b1);
    run_n("t6_a", 2);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h70;
    run_n("t6_b", 1);
    wr_en = 1'b0;
    run_n("t6_c", exp_q.size());
    Reset = 1'b1;
    #2;
    model_reset();
    chk_idle("t6_reset");
    Reset = 1'b0;
    tick();
    chk_idle("t6_after");

    // Random patterns
    for (int it = 0; it < 8; it++) begin
      int last;
      last = $urandom_range(0, 3);
      for (int i = 0; i <= last; i++) wr(i, 8'($urandom));
      for (int i = 0; i <= last; i++) push_step(i, plen(i), GAP);
      push_done();
      do_start(4'(last), 1'b0);
      run_n("rnd", exp_q.size());
      chk_idle("rnd_end");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
